// File: rtl/preset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : preset_sequencer
//  Purpose  : Drives the synchronous preset (PD) pins of NBANK flop banks.
//             After reset release every bank is preset together for HOLD
//             cycles (power-on sequence). Afterwards a requester may trigger
//             a staggered preset of a masked subset of banks, one bank at a
//             time. Each bank's PD pulse lasts HOLD cycles and is followed by
//             GAP idle cycles. Staggering limits simultaneous switching.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      clock, rising edge
//    rst_n  in   1      asynchronous active-low reset
//    req    in   1      level request for a masked preset sequence
//    mask   in   NBANK  banks to preset, captured together with ack
//    ack    out  1      one-cycle pulse: request accepted, mask captured
//    busy   out  1      high while a power-on or requested sequence runs
//    done   out  1      one-cycle pulse: sequence complete
//    pd     out  NBANK  per-bank synchronous preset, active high
//    cur    out  IW     index of the bank being serviced (held in idle)
// ============================================================================
module preset_sequencer #(
  parameter int NBANK = 4,
  parameter int HOLD  = 4,
  parameter int GAP   = 2,
  parameter int CW    = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req,
  input  logic [NBANK-1:0]                              mask,
  output logic                                          ack,
  output logic                                          busy,
  output logic                                          done,
  output logic [NBANK-1:0]                              pd,
  output logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0]  cur
);

  localparam int IW = (NBANK > 1) ? $clog2(NBANK) : 1;

  localparam logic [CW-1:0]    HOLD_M1 = CW'(HOLD - 1);
  localparam logic [CW-1:0]    GAP_M1  = CW'(GAP - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [NBANK-1:0] ONE_HOT = NBANK'(1);

  localparam logic [1:0] S_POR    = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ASSERT = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [NBANK-1:0] cap_mask;
  logic [NBANK-1:0] pd_r;
  logic             ack_r;
  logic             done_r;
  logic             busy_r;

  // Next values
  logic [1:0]       state_nx;
  logic [CW-1:0]    cnt_nx;
  logic [IW-1:0]    idx_nx;
  logic [NBANK-1:0] cap_mask_nx;
  logic [NBANK-1:0] pd_nx;
  logic             ack_nx;
  logic             done_nx;
  logic             busy_nx;

  // Bank search results
  logic             first_found;
  logic [IW-1:0]    first_idx;
  logic             next_found;
  logic [IW-1:0]    next_idx;

  // --------------------------------------------------------------------------
  // Bank search. Scanning from the top down leaves the lowest qualifying bit
  // in the result, so clear mask bits are skipped without spending cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_found = 1'b1;
        first_idx   = IW'(i);
      end
      if (cap_mask[i] && (i > int'(idx))) begin
        next_found = 1'b1;
        next_idx   = IW'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register (also holds every output so all outputs are registered)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_POR;
      cnt      <= HOLD_M1;
      idx      <= '0;
      cap_mask <= '0;
      pd_r     <= '1;
      ack_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      cap_mask <= cap_mask_nx;
      pd_r     <= pd_nx;
      ack_r    <= ack_nx;
      done_r   <= done_nx;
      busy_r   <= busy_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    idx_nx      = idx;
    cap_mask_nx = cap_mask;
    case (state)
      S_POR: begin
        if (cnt != '0) cnt_nx = cnt - CNT_ONE;
        else           state_nx = S_IDLE;
      end
      S_IDLE: begin
        // req is only looked at here; requests during a sequence are dropped.
        if (req && first_found) begin
          cap_mask_nx = mask;
          idx_nx      = first_idx;
          cnt_nx      = HOLD_M1;
          state_nx    = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_ONE;
        end else begin
          cnt_nx   = GAP_M1;
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_ONE;
        end else if (next_found) begin
          idx_nx   = next_idx;
          cnt_nx   = HOLD_M1;
          state_nx = S_ASSERT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_POR;
        cnt_nx   = HOLD_M1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    pd_nx   = pd_r;
    ack_nx  = 1'b0;
    done_nx = 1'b0;
    busy_nx = busy_r;
    case (state)
      S_POR: begin
        if (cnt == '0) begin
          pd_nx   = '0;
          busy_nx = 1'b0;
          done_nx = 1'b1;
        end else begin
          pd_nx   = '1;
          busy_nx = 1'b1;
        end
      end
      S_IDLE: begin
        if (req) begin
          ack_nx = 1'b1;
          if (first_found) begin
            busy_nx = 1'b1;
            pd_nx   = ONE_HOT << first_idx;
          end else begin
            // Empty mask: accept and complete on the same edge.
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end
      end
      S_ASSERT: begin
        if (cnt == '0) pd_nx = '0;
      end
      S_GAP: begin
        if (cnt == '0) begin
          if (next_found) begin
            pd_nx = ONE_HOT << next_idx;
          end else begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
          end
        end
      end
      default: begin
        pd_nx   = '1;
        busy_nx = 1'b1;
      end
    endcase
  end

  assign pd   = pd_r;
  assign ack  = ack_r;
  assign done = done_r;
  assign busy = busy_r;
  assign cur  = idx;

endmodule
`default_nettype wire
